// File: rtl/dma_job_scheduler.sv
// Round-robin DMA job scheduler: programs a shared AXI DMA over
// AXI-Lite, then polls its status register until done or timeout.
module dma_job_scheduler #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_rd_addr,
  input  logic [NREQ*32-1:0]      req_rd_len,
  input  logic [NREQ*32-1:0]      req_wr_addr,
  input  logic [NREQ*32-1:0]      req_wr_len,
  output logic                    done_valid,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    done_err,
  output logic                    busy,
  output logic                    lite_wren,
  output logic [31:0]             lite_wr_addr,
  output logic [31:0]             lite_wr_data,
  input  logic                    lite_wr_done,
  output logic                    lite_rden,
  output logic [31:0]             lite_rd_addr,
  input  logic                    lite_rd_done,
  input  logic [31:0]             lite_rd_data
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);

  typedef enum logic [3:0] {
    IDLE,
    W_RDBASE,
    W_RDLEN,
    W_WRBASE,
    W_WRLEN,
    W_STOP,
    W_START,
    POLL_WAIT,
    POLL_RD,
    DONE
  } state_t;

  state_t        state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] id_q;
  logic [31:0]   rd_len_q;
  logic [31:0]   wr_base_q;
  logic [31:0]   wr_len_q;
  logic [GW-1:0] gap_q;
  logic [PW-1:0] poll_q;
  logic          wren_q;
  logic          rden_q;
  logic          dvalid_q;
  logic          derr_q;
  logic [31:0]   waddr_q;
  logic [31:0]   wdata_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [31:0]     gnt_off;
  logic            unused_rd;

  assign unused_rd = ^lite_rd_data[31:1];

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    logic [IW-1:0] j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = IW'((32'(rr_q) + k) % NREQ);
      if (!gnt_any && req_valid[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = j;
        gnt_any = 1'b1;
      end
    end
  end

  assign gnt_off   = 32'(gnt_idx) * 32;
  assign req_ready = (state_q == IDLE && !ARESET) ? gnt : '0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rr_q      <= IW'(NREQ - 1);
      id_q      <= '0;
      rd_len_q  <= '0;
      wr_base_q <= '0;
      wr_len_q  <= '0;
      gap_q     <= '0;
      poll_q    <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      derr_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      dvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (gnt_any) begin
          id_q      <= gnt_idx;
          rr_q      <= gnt_idx;
          rd_len_q  <= req_rd_len[gnt_off +: 32];
          wr_base_q <= req_wr_addr[gnt_off +: 32];
          wr_len_q  <= req_wr_len[gnt_off +: 32];
          poll_q    <= '0;
          wren_q    <= 1'b1;
          waddr_q   <= 32'h0;
          wdata_q   <= req_rd_addr[gnt_off +: 32];
          state_q   <= W_RDBASE;
        end
        W_RDBASE: if (lite_wr_done) begin
          wren_q  <= 1'b1;
          waddr_q <= 32'h4;
          wdata_q <= rd_len_q;
          state_q <= W_RDLEN;
        end
        W_RDLEN: if (lite_wr_done) begin
          wren_q  <= 1'b1;
          waddr_q <= 32'h8;
          wdata_q <= wr_base_q;
          state_q <= W_WRBASE;
        end
        W_WRBASE: if (lite_wr_done) begin
          wren_q  <= 1'b1;
          waddr_q <= 32'hC;
          wdata_q <= wr_len_q;
          state_q <= W_WRLEN;
        end
        W_WRLEN: if (lite_wr_done) begin
          wren_q  <= 1'b1;
          waddr_q <= 32'h10;
          wdata_q <= 32'h0;
          state_q <= W_STOP;
        end
        W_STOP: if (lite_wr_done) begin
          wren_q  <= 1'b1;
          waddr_q <= 32'h10;
          wdata_q <= 32'h1;
          state_q <= W_START;
        end
        W_START: if (lite_wr_done) begin
          gap_q   <= '0;
          state_q <= POLL_WAIT;
        end
        POLL_WAIT: begin
          if (gap_q == GW'(POLL_GAP - 1)) begin
            rden_q  <= 1'b1;
            state_q <= POLL_RD;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        POLL_RD: if (lite_rd_done) begin
          if (lite_rd_data[0]) begin
            dvalid_q <= 1'b1;
            derr_q   <= 1'b0;
            state_q  <= DONE;
          end else if (poll_q == PW'(MAX_POLLS - 1)) begin
            poll_q   <= poll_q + 1'b1;
            dvalid_q <= 1'b1;
            derr_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            poll_q  <= poll_q + 1'b1;
            gap_q   <= '0;
            state_q <= POLL_WAIT;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign done_valid   = dvalid_q;
  assign done_id      = id_q;
  assign done_err     = derr_q;
  assign lite_wren    = wren_q;
  assign lite_wr_addr = waddr_q;
  assign lite_wr_data = wdata_q;
  assign lite_rden    = rden_q;
  assign lite_rd_addr = 32'h14;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Bench for dma_job_scheduler: transaction-level model plus AXI-Lite
// slave, compared every cycle, with literal expectations per scenario.
module tb_dma_job_scheduler;
  localparam int NREQ      = 2;
  localparam int POLL_GAP  = 2;
  localparam int MAX_POLLS = 4;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [63:0]     req_rd_addr;
  logic [63:0]     req_rd_len;
  logic [63:0]     req_wr_addr;
  logic [63:0]     req_wr_len;
  logic            done_valid;
  logic [0:0]      done_id;
  logic            done_err;
  logic            busy;
  logic            lite_wren;
  logic [31:0]     lite_wr_addr;
  logic [31:0]     lite_wr_data;
  logic            lite_wr_done;
  logic            lite_rden;
  logic [31:0]     lite_rd_addr;
  logic            lite_rd_done;
  logic [31:0]     lite_rd_data;

  dma_job_scheduler #(
    .NREQ(NREQ), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_addr(req_rd_addr), .req_rd_len(req_rd_len),
    .req_wr_addr(req_wr_addr), .req_wr_len(req_wr_len),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
    .busy(busy),
    .lite_wren(lite_wren), .lite_wr_addr(lite_wr_addr),
    .lite_wr_data(lite_wr_data), .lite_wr_done(lite_wr_done),
    .lite_rden(lite_rden), .lite_rd_addr(lite_rd_addr),
    .lite_rd_done(lite_rd_done), .lite_rd_data(lite_rd_data)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int wr_dly  = 1;
  int rd_dly  = 1;
  int stat_at = 3;
  bit spur    = 1'b0;

  bit          m_idle = 1'b1;
  int          m_rr = NREQ - 1;
  int          m_id = 0;
  int          m_reads = 0;
  bit          exp_err = 1'b0;
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  int          wr_due = -1;
  int          rd_due = -1;
  int          done_due = -1;
  int          w_done_at = -1;
  int          r_done_at = -1;
  bit          w_active = 1'b0;

  int          grant_log[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int          rd_cycles[$];
  int          done_ids[$];
  int          done_errs[$];
  int          wren_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h",
               nm, cyc, act, want);
    end
  endtask

  // Slave + model + per-cycle compare, all sampled on the falling edge.
  always @(negedge ACLK) begin
    int gi;
    logic [1:0] eg;
    bit st;
    cyc++;
    lite_wr_done = spur;
    lite_rd_done = spur;
    lite_rd_data = spur ? 32'h1 : 32'h0;
    if (ARESET) begin
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done_valid", done_valid, 1'b0);
      chk("rst_wren", lite_wren, 1'b0);
      chk("rst_rden", lite_rden, 1'b0);
      chk("rst_wr_addr", lite_wr_addr, 32'h0);
      chk("rst_wr_data", lite_wr_data, 32'h0);
      m_idle = 1'b1;
      m_rr = NREQ - 1;
      wq_a.delete();
      wq_d.delete();
      wr_due = -1;
      rd_due = -1;
      done_due = -1;
      w_done_at = -1;
      r_done_at = -1;
      w_active = 1'b0;
    end else begin
      if (lite_wren) wren_cnt++;
      chk("busy", busy, !m_idle);
      eg = '0;
      gi = -1;
      if (m_idle)
        for (int k = 1; k <= NREQ; k++)
          if (gi < 0 && req_valid[(m_rr + k) % NREQ])
            gi = (m_rr + k) % NREQ;
      if (gi >= 0) eg[gi] = 1'b1;
      chk("req_ready", req_ready, eg);
      if (gi >= 0) begin
        grant_log.push_back(gi);
        m_idle = 1'b0;
        m_id = gi;
        m_rr = gi;
        m_reads = 0;
        wq_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10};
        wq_d = '{req_rd_addr[gi*32 +: 32], req_rd_len[gi*32 +: 32],
                 req_wr_addr[gi*32 +: 32], req_wr_len[gi*32 +: 32],
                 32'h0, 32'h1};
        wr_due = cyc + 1;
      end

      chk("wren", lite_wren, cyc == wr_due);
      if (cyc == wr_due) begin
        w_active = 1'b1;
        w_done_at = cyc + wr_dly;
        wr_due = -1;
        log_a.push_back(lite_wr_addr);
        log_d.push_back(lite_wr_data);
      end
      if (w_active) begin
        chk("wr_addr", lite_wr_addr, wq_a[0]);
        chk("wr_data", lite_wr_data, wq_d[0]);
        if (cyc == w_done_at) begin
          lite_wr_done = 1'b1;
          w_active = 1'b0;
          void'(wq_a.pop_front());
          void'(wq_d.pop_front());
          if (wq_a.size() > 0) wr_due = cyc + 1;
          else rd_due = cyc + POLL_GAP + 1;
        end
      end

      chk("rden", lite_rden, cyc == rd_due);
      if (cyc == rd_due) begin
        chk("rd_addr", lite_rd_addr, 32'h14);
        rd_cycles.push_back(cyc);
        r_done_at = cyc + rd_dly;
        rd_due = -1;
      end
      if (cyc == r_done_at) begin
        r_done_at = -1;
        m_reads++;
        st = (stat_at != 0) && (m_reads >= stat_at);
        lite_rd_done = 1'b1;
        lite_rd_data = {31'h7FFF_FFFF, st};
        if (st) begin
          done_due = cyc + 1;
          exp_err = 1'b0;
        end else if (m_reads == MAX_POLLS) begin
          done_due = cyc + 1;
          exp_err = 1'b1;
        end else begin
          rd_due = cyc + POLL_GAP + 1;
        end
      end

      chk("done_valid", done_valid, cyc == done_due);
      if (cyc == done_due) begin
        chk("done_id", done_id, m_id);
        chk("done_err", done_err, exp_err);
        done_ids.push_back(int'(done_id));
        done_errs.push_back(int'(done_err));
        done_due = -1;
        m_idle = 1'b1;
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    log_a.delete();
    log_d.delete();
    rd_cycles.delete();
    done_ids.delete();
    done_errs.delete();
    wren_cnt = 0;
  endtask

  task automatic run_job(input int i, input bit scramble);
    bit ok;
    logic [31:0] keep_len;
    logic [31:0] keep_wa;
    @(posedge ACLK);
    #1 req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      ok = req_ready[i];
    end
    chk("grant_seen", ok, 1'b1);
    @(posedge ACLK);
    #1 req_valid[i] = 1'b0;
    keep_len = req_rd_len[i*32 +: 32];
    keep_wa  = req_wr_addr[i*32 +: 32];
    if (scramble) begin
      req_rd_len[i*32 +: 32]  = 32'hDEAD_BEEF;
      req_wr_addr[i*32 +: 32] = 32'hCAFE_0000;
    end
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge ACLK);
      ok = done_valid;
    end
    chk("done_seen", ok, 1'b1);
    @(posedge ACLK);
    #1;
    req_rd_len[i*32 +: 32]  = keep_len;
    req_wr_addr[i*32 +: 32] = keep_wa;
  endtask

  initial begin
    logic [31:0] ea [6];
    logic [31:0] ed [6];
    bit ok;
    int nd;
    req_valid   = '0;
    req_rd_addr = {32'h0000_1000, 32'h0};
    req_rd_len  = {32'd63, 32'd299};
    req_wr_addr = {32'h0000_2000, 32'd512};
    req_wr_len  = {32'd63, 32'd299};
    repeat (3) @(posedge ACLK);
    #1;
    chk("t0_busy", busy, 1'b0);
    chk("t0_ready", req_ready, 2'b00);
    ARESET = 1'b0;

    // Single job, status done on the third read
    clear_logs();
    wr_dly = 1; rd_dly = 1; stat_at = 3;
    run_job(0, 1'b1);
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10};
    ed = '{32'd0, 32'd299, 32'd512, 32'd299, 32'd0, 32'd1};
    chk("t1_nwr", log_a.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("t1_wr_addr", log_a[k], ea[k]);
      chk("t1_wr_data", log_d[k], ed[k]);
    end
    chk("t1_nrd", rd_cycles.size(), 3);
    chk("t1_id", done_ids[0], 0);
    chk("t1_err", done_errs[0], 0);

    // Spurious completions while idle
    nd = wren_cnt;
    spur = 1'b1;
    repeat (6) @(posedge ACLK);
    #1 spur = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_wren", wren_cnt, nd);

    // Both requesters held from reset: alternate grants
    ARESET = 1'b1;
    req_valid = 2'b11;
    repeat (2) @(posedge ACLK);
    #1;
    clear_logs();
    stat_at = 1;
    ARESET = 1'b0;
    nd = 0;
    for (int n = 0; n < 4000 && nd < 4; n++) begin
      @(negedge ACLK);
      if (done_valid) nd++;
    end
    @(posedge ACLK);
    #1 req_valid = 2'b00;
    chk("t2_ndone", nd, 4);
    chk("t2_ngrant", grant_log.size(), 4);
    chk("t2_g0", grant_log[0], 0);
    chk("t2_g1", grant_log[1], 1);
    chk("t2_g2", grant_log[2], 0);
    chk("t2_g3", grant_log[3], 1);

    // Status never set: timeout after MAX_POLLS reads
    clear_logs();
    stat_at = 0;
    run_job(1, 1'b0);
    chk("t3_nrd", rd_cycles.size(), 4);
    for (int k = 0; k < 3; k++)
      chk("t3_gap", rd_cycles[k+1] - rd_cycles[k], 4);
    chk("t3_err", done_errs[0], 1);
    chk("t3_id", done_ids[0], 1);

    // Slow write responses
    clear_logs();
    wr_dly = 20; stat_at = 1;
    run_job(0, 1'b0);
    chk("t4_wren_cycles", wren_cnt, 6);
    chk("t4_nwr", log_a.size(), 6);
    chk("t4_last_data", log_d[5], 32'h1);

    // Reset during the wr_len write, then a clean req1 job
    wr_dly = 10;
    @(posedge ACLK);
    #1 req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      ok = req_ready[1];
    end
    chk("t5_grant", ok, 1'b1);
    @(posedge ACLK);
    #1 req_valid[1] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge ACLK);
      ok = lite_wren && (lite_wr_addr == 32'hC);
    end
    chk("t5_reach_wrlen", ok, 1'b1);
    @(posedge ACLK);
    #3 ARESET = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_wr_addr", lite_wr_addr, 32'h0);
    chk("t5_wr_data", lite_wr_data, 32'h0);
    chk("t5_done_valid", done_valid, 1'b0);
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    clear_logs();
    wr_dly = 1;
    run_job(1, 1'b0);
    chk("t5_g", grant_log[0], 1);
    chk("t5_nwr", log_a.size(), 6);
    chk("t5_first_addr", log_a[0], 32'h0);
    chk("t5_first_data", log_d[0], 32'h0000_1000);
    chk("t5_len_data", log_d[1], 32'd63);
    chk("t5_id", done_ids[0], 1);
    chk("t5_ndone", done_ids.size(), 1);

    repeat (3) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
